// File: rtl/cociente_pkg.sv
// Shared types and helpers for the sequential quotient register.
package cociente_pkg;

  typedef enum logic [1:0] {IDLE, ACUM, FIN} cociente_estado_t;

  function automatic int unsigned idx_w(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/module_cociente_seq_indice.sv
// Up/down bit-index counter for the quotient register, with a last-index flag.
module module_indice_cnt
  import cociente_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter bit          MSB_PRIMERO = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic                       step,
  output logic [idx_w(WIDTH)-1:0]    indice,
  output logic                       ultimo
);

  localparam int unsigned    IW      = idx_w(WIDTH);
  localparam logic [IW-1:0]  PRIMERO = MSB_PRIMERO ? IW'(WIDTH - 1) : '0;
  localparam logic [IW-1:0]  FINAL   = MSB_PRIMERO ? '0 : IW'(WIDTH - 1);

  logic [IW-1:0] idx_q, idx_d;

  // The index parks on the last position; the owner decides when to reload it.
  always_comb begin
    idx_d = idx_q;
    if (load) begin
      idx_d = PRIMERO;
    end else if (step && !ultimo) begin
      idx_d = MSB_PRIMERO ? idx_q - IW'(1) : idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= PRIMERO;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign indice = idx_q;
  assign ultimo = (idx_q == FINAL);

endmodule

// File: rtl/module_cociente_seq.sv
// Sequential quotient register: one bit (~signo) per accepted step, start/busy/done handshake.
// Optional q_cero zero-quotient flag enabled by macro COCIENTE_CERO_FLAG_EN.
module module_cociente_seq
  import cociente_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter bit          MSB_PRIMERO = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     enable,
  input  logic                     signo,
  output logic [WIDTH-1:0]         Q,
  output logic [idx_w(WIDTH)-1:0]  indice,
  output logic                     busy,
  output logic                     done
`ifdef COCIENTE_CERO_FLAG_EN
  ,
  output logic                     q_cero
`endif
);

  cociente_estado_t          estado_q;
  logic [WIDTH-1:0]          q_q, q_d;
  logic                      busy_q, done_q;
  logic                      cnt_load, cnt_step, cnt_ultimo;
  logic [idx_w(WIDTH)-1:0]   cnt_indice;
`ifdef COCIENTE_CERO_FLAG_EN
  logic                      q_cero_q;
`endif

  assign cnt_load = ((estado_q == IDLE) && start) || (estado_q == FIN);
  assign cnt_step = (estado_q == ACUM) && enable;

  module_indice_cnt #(
    .WIDTH       (WIDTH),
    .MSB_PRIMERO (MSB_PRIMERO)
  ) u_indice (
    .clk    (clk),
    .rst    (rst),
    .load   (cnt_load),
    .step   (cnt_step),
    .indice (cnt_indice),
    .ultimo (cnt_ultimo)
  );

  always_comb begin
    q_d             = q_q;
    q_d[cnt_indice] = ~signo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= IDLE;
      q_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef COCIENTE_CERO_FLAG_EN
      q_cero_q <= 1'b0;
`endif
    end else begin
      case (estado_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            q_q      <= '0;
            busy_q   <= 1'b1;
            estado_q <= ACUM;
          end
        end
        ACUM: begin
          if (enable) begin
            q_q <= q_d;
            if (cnt_ultimo) begin
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              estado_q <= FIN;
`ifdef COCIENTE_CERO_FLAG_EN
              q_cero_q <= (q_d == '0);
`endif
            end
          end
        end
        FIN: begin
          done_q   <= 1'b0;
          estado_q <= IDLE;
`ifdef COCIENTE_CERO_FLAG_EN
          q_cero_q <= 1'b0;
`endif
        end
        default: estado_q <= IDLE;
      endcase
    end
  end

  assign Q      = q_q;
  assign indice = cnt_indice;
  assign busy   = busy_q;
  assign done   = done_q;
`ifdef COCIENTE_CERO_FLAG_EN
  assign q_cero = q_cero_q;
`endif

endmodule
